// File: rtl/tube_pkg.sv
// tube_pkg
// Shared constants for the seven-segment tube scanner.
//   HEX_SEG      : segment patterns {g,f,e,d,c,b,a} for nibble values 0..F
//   SEG_A..SEG_DP: bit positions of each segment on the 8-bit segment bus
package tube_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Entry n is the pattern for hex digit n (entry 15 written first).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode
// Combinational nibble to seven-segment decoder.
// Ports:
//   nibble : 4-bit hex value
//   seg    : segments {g,f,e,d,c,b,a}, bit SEG_A = segment a, active-high
module seg_hex_decode
  import tube_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  logic [6:0] pattern;

  assign pattern = HEX_SEG[nibble];

  // Table bits are already laid out at the bus positions of segments a..g.
  assign seg[SEG_A] = pattern[SEG_A];
  assign seg[SEG_B] = pattern[SEG_B];
  assign seg[SEG_C] = pattern[SEG_C];
  assign seg[SEG_D] = pattern[SEG_D];
  assign seg[SEG_E] = pattern[SEG_E];
  assign seg[SEG_F] = pattern[SEG_F];
  assign seg[SEG_G] = pattern[SEG_G];

endmodule

// File: rtl/tube_scanner.sv
// tube_scanner
// Multiplexed seven-segment scanner with double-buffered, frame-synchronous
// updates, hex/raw modes, leading-zero suppression, per-digit blanking,
// an anti-ghost guard at the start of each dwell and PWM brightness.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   load        : capture data/mode/dp/blank/lz into the pending buffer
//   data        : byte i drives digit i (hex mode uses the low nibble)
//   mode        : 0 = hex decode, 1 = raw segments
//   dp          : decimal point per digit (hex mode)
//   blank       : per-digit dark
//   lz          : leading-zero suppression enable (hex mode)
//   brightness  : live PWM duty
//   tube_dig    : one-hot digit select (active-high)
//   tube_seg    : {dp,g,f,e,d,c,b,a} (active-high)
//   frame_done  : one-cycle pulse after each completed frame
//   pending     : a buffered update is waiting for the frame boundary
module tube_scanner
  import tube_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_WIDTH  = 17,
  parameter int PWM_BITS   = 3,
  parameter int GUARD      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [8*NUM_DIGITS-1:0] data,
  input  logic                    mode,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    lz,
  input  logic [PWM_BITS-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   tube_dig,
  output logic [7:0]              tube_seg,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_WIDTH-1:0] GUARD_CNT = DIV_WIDTH'(GUARD);

  logic [DIV_WIDTH-1:0] dwell;
  logic [IDX_W-1:0]     idx;
  logic                 dwell_wrap;
  logic                 boundary;

  // Pending (buffer) and displayed (active) copies of the frame content.
  logic [8*NUM_DIGITS-1:0] buf_data,  act_data;
  logic                    buf_mode,  act_mode;
  logic [NUM_DIGITS-1:0]   buf_dp,    act_dp;
  logic [NUM_DIGITS-1:0]   buf_blank, act_blank;
  logic                    buf_lz,    act_lz;
  logic                    pend_q;

  logic [7:0]            cur_byte;
  logic                  cur_dp;
  logic                  cur_blank;
  logic                  upper_zero;
  logic [6:0]            hex_seg;
  logic                  suppress;
  logic [PWM_BITS-1:0]   phase;
  logic                  lit;
  logic [7:0]            seg_next;
  logic [NUM_DIGITS-1:0] dig_next;

  assign dwell_wrap = &dwell;
  assign boundary   = dwell_wrap && (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell <= '0;
      idx   <= '0;
    end else begin
      dwell <= dwell + 1'b1;
      if (dwell_wrap) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
    end
  end

  // A load on the boundary cycle still promotes the previous buffer; the new
  // value lands in the buffer and keeps pending set for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_data  <= '0;
      buf_mode  <= 1'b0;
      buf_dp    <= '0;
      buf_blank <= '0;
      buf_lz    <= 1'b0;
      pend_q    <= 1'b0;
      act_data  <= '0;
      act_mode  <= 1'b0;
      act_dp    <= '0;
      act_blank <= '1;
      act_lz    <= 1'b0;
    end else begin
      if (boundary && pend_q) begin
        act_data  <= buf_data;
        act_mode  <= buf_mode;
        act_dp    <= buf_dp;
        act_blank <= buf_blank;
        act_lz    <= buf_lz;
      end
      if (load) begin
        buf_data  <= data;
        buf_mode  <= mode;
        buf_dp    <= dp;
        buf_blank <= blank;
        buf_lz    <= lz;
        pend_q    <= 1'b1;
      end else if (boundary) begin
        pend_q <= 1'b0;
      end
    end
  end

  // Select the current digit's fields and find whether this digit and all
  // more significant nibbles are zero (for leading-zero suppression).
  always_comb begin
    cur_byte   = '0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_byte  = act_data[8*i +: 8];
        cur_dp    = act_dp[i];
        cur_blank = act_blank[i];
      end
      if ((IDX_W'(i) >= idx) && (act_data[8*i +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
  end

  seg_hex_decode u_hex_decode (
    .nibble (cur_byte[3:0]),
    .seg    (hex_seg)
  );

  assign suppress = act_lz && (idx != '0) && upper_zero;
  assign phase    = dwell[DIV_WIDTH-1 -: PWM_BITS];
  assign lit      = (dwell >= GUARD_CNT) && (phase <= brightness) && !cur_blank;

  always_comb begin
    seg_next = '0;
    dig_next = '0;
    if (act_mode) begin
      seg_next = cur_byte;
    end else begin
      seg_next[SEG_DP]       = cur_dp;
      seg_next[SEG_G:SEG_A]  = suppress ? 7'h00 : hex_seg;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig_next[i] = lit && (idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tube_dig   <= '0;
      tube_seg   <= '0;
      frame_done <= 1'b0;
    end else begin
      tube_dig   <= dig_next;
      tube_seg   <= lit ? seg_next : 8'h00;
      frame_done <= boundary;
    end
  end

  assign pending = pend_q;

endmodule
